// File: rtl/cache_6502_assoc_if.sv
// CPU-side and memory-side bus of the 6502 fully-associative cache.
// The cache itself uses the slave modport; the bus owner (CPU + memory model) uses master.
interface cache_6502_assoc_if;
   logic [15:0] cpu_addr;
   logic        cpu_en;
   logic        cpu_wr;
   logic        cpu_iread;
   logic [7:0]  cpu_wdata;
   logic        cpu_rdy;
   logic [7:0]  cpu_rdata;
   logic [15:0] mem_addr;
   logic        mem_en;
   logic        mem_wr;
   logic        mem_rburst;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata0;
   logic        mem_rdata_load;

   modport slave (
      input  cpu_addr, cpu_en, cpu_wr, cpu_iread, cpu_wdata, mem_rdata0, mem_rdata_load,
      output cpu_rdy, cpu_rdata, mem_addr, mem_en, mem_wr, mem_rburst, mem_wdata
   );

   modport master (
      output cpu_addr, cpu_en, cpu_wr, cpu_iread, cpu_wdata, mem_rdata0, mem_rdata_load,
      input  cpu_rdy, cpu_rdata, mem_addr, mem_en, mem_wr, mem_rburst, mem_wdata
   );
endinterface

// File: rtl/cache_6502_assoc.sv
// Fully-associative, write-through instruction cache for a 6502-style bus.
// Instruction-fetch misses burst-fill a round-robin victim line; everything else bypasses.
module cache_6502_assoc #(
   parameter int unsigned NUM_LINES  = 4,
   parameter int unsigned LINE_BYTES = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              icache_en,
   cache_6502_assoc_if.slave bus,
   output logic [15:0]       hit_count
);
   localparam int unsigned OFF_W = $clog2(LINE_BYTES);
   localparam int unsigned TAG_W = 16 - OFF_W;
   localparam int unsigned IDX_W = $clog2(NUM_LINES);

   typedef enum logic [1:0] {StReady, StMemWait, StIfill} state_e;

   state_e                 state_q;
   logic [NUM_LINES-1:0]   valid_q;
   logic [TAG_W-1:0]       tag_q  [NUM_LINES];
   logic [7:0]             data_q [NUM_LINES][LINE_BYTES];
   logic [IDX_W-1:0]       victim_q;
   logic [IDX_W-1:0]       fill_line_q;
   logic [OFF_W-1:0]       fill_off_q;
   logic [OFF_W-1:0]       req_off_q;
   logic                   fill_keep_q;
   logic [7:0]             rdata_q;
   logic [15:0]            hit_count_q;
   logic [15:0]            mem_addr_q;
   logic                   mem_en_q;
   logic                   mem_wr_q;
   logic                   mem_rburst_q;
   logic [7:0]             mem_wdata_q;

   logic [TAG_W-1:0]       req_tag;
   logic [OFF_W-1:0]       req_off;
   logic                   hit;
   logic [IDX_W-1:0]       hit_idx;
   logic                   accept;
   logic                   rd_hit;
   logic                   wr_hit;
   logic                   fill_start;
   logic                   beat;
   logic                   last_beat;

   assign req_tag = bus.cpu_addr[15:OFF_W];
   assign req_off = bus.cpu_addr[OFF_W-1:0];

   // Descending scan so the lowest matching index is the one left standing.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = int'(NUM_LINES) - 1; i >= 0; i--) begin
         if (valid_q[i] && (tag_q[i] == req_tag)) begin
            hit     = 1'b1;
            hit_idx = IDX_W'(i);
         end
      end
      hit = hit & icache_en;
   end

   assign accept     = (state_q == StReady) && bus.cpu_en;
   assign rd_hit     = accept && !bus.cpu_wr && hit;
   assign wr_hit     = accept && bus.cpu_wr && hit;
   assign fill_start = accept && !bus.cpu_wr && !hit && icache_en && bus.cpu_iread;
   assign beat       = (state_q == StIfill) && bus.mem_rdata_load;
   assign last_beat  = beat && (fill_off_q == OFF_W'(LINE_BYTES - 1));

   // Line storage needs no reset: valid_q alone decides whether it is visible.
   always_ff @(posedge clk) begin
      if (fill_start) begin
         tag_q[victim_q] <= req_tag;
      end
      if (wr_hit) begin
         data_q[hit_idx][req_off] <= bus.cpu_wdata;
      end
      if (beat) begin
         data_q[fill_line_q][fill_off_q] <= bus.mem_rdata0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StReady;
         valid_q      <= '0;
         victim_q     <= '0;
         fill_line_q  <= '0;
         fill_off_q   <= '0;
         req_off_q    <= '0;
         fill_keep_q  <= 1'b0;
         rdata_q      <= 8'h00;
         hit_count_q  <= 16'h0000;
         mem_addr_q   <= 16'h0000;
         mem_en_q     <= 1'b0;
         mem_wr_q     <= 1'b0;
         mem_rburst_q <= 1'b0;
         mem_wdata_q  <= 8'h00;
      end else begin
         unique case (state_q)
            StReady: begin
               if (bus.cpu_en) begin
                  req_off_q <= req_off;
                  if (rd_hit) begin
                     rdata_q <= data_q[hit_idx][req_off];
                     if (hit_count_q != 16'hFFFF) begin
                        hit_count_q <= hit_count_q + 16'd1;
                     end
                  end else if (fill_start) begin
                     mem_en_q          <= 1'b1;
                     mem_rburst_q      <= 1'b1;
                     mem_wr_q          <= 1'b0;
                     mem_addr_q        <= {req_tag, {OFF_W{1'b0}}};
                     valid_q[victim_q] <= 1'b0;
                     fill_line_q       <= victim_q;
                     fill_off_q        <= '0;
                     fill_keep_q       <= 1'b1;
                     state_q           <= StIfill;
                  end else begin
                     mem_en_q     <= 1'b1;
                     mem_rburst_q <= 1'b0;
                     mem_wr_q     <= bus.cpu_wr;
                     mem_wdata_q  <= bus.cpu_wdata;
                     mem_addr_q   <= bus.cpu_addr;
                     state_q      <= StMemWait;
                  end
               end
            end
            StMemWait: begin
               if (bus.mem_rdata_load) begin
                  if (!mem_wr_q) begin
                     rdata_q <= bus.mem_rdata0;
                  end
                  mem_en_q <= 1'b0;
                  mem_wr_q <= 1'b0;
                  state_q  <= StReady;
               end
            end
            StIfill: begin
               // A disable seen at any point of the burst leaves the line invalid.
               if (!icache_en) begin
                  fill_keep_q <= 1'b0;
               end
               if (beat) begin
                  fill_off_q <= fill_off_q + OFF_W'(1);
                  if (fill_off_q == req_off_q) begin
                     rdata_q <= bus.mem_rdata0;
                  end
                  if (last_beat) begin
                     if (fill_keep_q && icache_en) begin
                        valid_q[fill_line_q] <= 1'b1;
                     end
                     victim_q     <= victim_q + IDX_W'(1);
                     fill_off_q   <= '0;
                     mem_en_q     <= 1'b0;
                     mem_rburst_q <= 1'b0;
                     state_q      <= StReady;
                  end
               end
            end
            default: state_q <= StReady;
         endcase
         if (!icache_en) begin
            valid_q  <= '0;
            victim_q <= '0;
         end
      end
   end

   assign bus.cpu_rdy    = (state_q == StReady);
   assign bus.cpu_rdata  = rdata_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_en     = mem_en_q;
   assign bus.mem_wr     = mem_wr_q;
   assign bus.mem_rburst = mem_rburst_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign hit_count      = hit_count_q;
endmodule

// File: tb/tb_cache_6502_assoc.sv
// Directed bench for cache_6502_assoc: fills, hits, write-through, eviction,
// disable during fill and reset during fill, against a fixed address-derived memory image.
module tb_cache_6502_assoc;
   logic        clk = 1'b0;
   logic        rst;
   logic        icache_en;
   logic [15:0] hit_count;
   int          checks = 0;
   int          errors = 0;

   int          r_beats;
   int          r_stall;
   logic [15:0] r_maddr;
   logic [7:0]  r_wdata;
   logic        r_wr;
   logic        r_burst;

   cache_6502_assoc_if bus ();

   cache_6502_assoc #(
      .NUM_LINES  (4),
      .LINE_BYTES (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .icache_en (icache_en),
      .bus       (bus),
      .hit_count (hit_count)
   );

   always #5 clk = ~clk;

   // Memory image: 0x1000..0x1007 -> A0..A7, each higher 4K page adds 0x10.
   function automatic logic [7:0] mem_byte(input logic [15:0] a);
      logic [7:0] hi;
      hi = {a[15:12] - 4'd1, 4'h0};
      return 8'hA0 + a[7:0] + hi;
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present one request at the current negedge, then act as memory until cpu_rdy returns.
   task automatic access(input logic [15:0] a, input logic wr, input logic iread,
                         input logic [7:0] wd, input int rst_beat, input int drop_beat);
      int n;
      bus.cpu_addr  = a;
      bus.cpu_en    = 1'b1;
      bus.cpu_wr    = wr;
      bus.cpu_iread = iread;
      bus.cpu_wdata = wd;
      r_beats = 0;
      r_stall = 0;
      r_maddr = 16'hxxxx;
      r_wdata = 8'hxx;
      r_wr    = 1'b0;
      r_burst = 1'b0;
      @(negedge clk);
      bus.cpu_en = 1'b0;
      n = 0;
      while (bus.cpu_rdy !== 1'b1 && n < 50) begin
         r_stall++;
         if (bus.mem_en === 1'b1) begin
            if (r_beats == 0) begin
               r_maddr = bus.mem_addr;
               r_wdata = bus.mem_wdata;
            end
            r_wr    = r_wr | bus.mem_wr;
            r_burst = r_burst | bus.mem_rburst;
            if (r_beats == rst_beat) rst = 1'b1;
            if (r_beats == drop_beat) icache_en = 1'b0;
            if (r_beats == drop_beat + 2) icache_en = 1'b1;
            bus.mem_rdata_load = 1'b1;
            bus.mem_rdata0 = mem_byte(bus.mem_addr + (bus.mem_rburst ? 16'(r_beats) : 16'd0));
            r_beats++;
         end
         @(negedge clk);
         bus.mem_rdata_load = 1'b0;
         n++;
      end
      chk("rdy_timeout", {15'd0, bus.cpu_rdy}, 16'd1);
   endtask

   initial begin
      rst                = 1'b1;
      icache_en          = 1'b1;
      bus.cpu_addr       = 16'h0000;
      bus.cpu_en         = 1'b0;
      bus.cpu_wr         = 1'b0;
      bus.cpu_iread      = 1'b0;
      bus.cpu_wdata      = 8'h00;
      bus.mem_rdata0     = 8'h00;
      bus.mem_rdata_load = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_rdy", {15'd0, bus.cpu_rdy}, 16'd1);
      chk("rst_mem_en", {15'd0, bus.mem_en}, 16'd0);
      chk("rst_rburst", {15'd0, bus.mem_rburst}, 16'd0);
      chk("rst_rdata", {8'd0, bus.cpu_rdata}, 16'h0000);
      chk("rst_hits", hit_count, 16'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_mem_en", {15'd0, bus.mem_en}, 16'd0);

      // First instruction fetch miss fills line 0.
      access(16'h1003, 1'b0, 1'b1, 8'h00, -1, -1);
      chk("fill1_addr", r_maddr, 16'h1000);
      chk("fill1_beats", 16'(r_beats), 16'd8);
      chk("fill1_burst", {15'd0, r_burst}, 16'd1);
      chk("fill1_wr", {15'd0, r_wr}, 16'd0);
      chk("fill1_stall", 16'(r_stall), 16'd8);
      chk("fill1_rdata", {8'd0, bus.cpu_rdata}, 16'h00A3);
      chk("fill1_mem_en", {15'd0, bus.mem_en}, 16'd0);

      // Hit in the same line.
      access(16'h1005, 1'b0, 1'b1, 8'h00, -1, -1);
      chk("hit1_mem_en", {15'd0, bus.mem_en}, 16'd0);
      chk("hit1_beats", 16'(r_beats), 16'd0);
      chk("hit1_rdata", {8'd0, bus.cpu_rdata}, 16'h00A5);
      chk("hit1_count", hit_count, 16'd1);

      // Write-through on a cached byte.
      access(16'h1002, 1'b1, 1'b0, 8'h5C, -1, -1);
      chk("wr_addr", r_maddr, 16'h1002);
      chk("wr_wr", {15'd0, r_wr}, 16'd1);
      chk("wr_wdata", {8'd0, r_wdata}, 16'h005C);
      chk("wr_burst", {15'd0, r_burst}, 16'd0);
      access(16'h1002, 1'b0, 1'b1, 8'h00, -1, -1);
      chk("wr_hit_beats", 16'(r_beats), 16'd0);
      chk("wr_hit_rdata", {8'd0, bus.cpu_rdata}, 16'h005C);
      chk("wr_hit_count", hit_count, 16'd2);

      // Four more fills; the fifth distinct line overwrites line 0.
      access(16'h2001, 1'b0, 1'b1, 8'h00, -1, -1);
      chk("fill2_rdata", {8'd0, bus.cpu_rdata}, 16'h00B1);
      access(16'h300A, 1'b0, 1'b1, 8'h00, -1, -1);
      chk("fill3_addr", r_maddr, 16'h3008);
      chk("fill3_rdata", {8'd0, bus.cpu_rdata}, 16'h00CA);
      access(16'h4013, 1'b0, 1'b1, 8'h00, -1, -1);
      chk("fill4_rdata", {8'd0, bus.cpu_rdata}, 16'h00E3);
      access(16'h5004, 1'b0, 1'b1, 8'h00, -1, -1);
      chk("fill5_beats", 16'(r_beats), 16'd8);
      chk("fill5_rdata", {8'd0, bus.cpu_rdata}, 16'h00E4);
      access(16'h2001, 1'b0, 1'b1, 8'h00, -1, -1);
      chk("hit2_beats", 16'(r_beats), 16'd0);
      chk("hit2_count", hit_count, 16'd3);
      access(16'h1003, 1'b0, 1'b1, 8'h00, -1, -1);
      chk("evict_beats", 16'(r_beats), 16'd8);
      chk("evict_rdata", {8'd0, bus.cpu_rdata}, 16'h00A3);

      // Data read miss bypasses and does not allocate.
      access(16'h6007, 1'b0, 1'b0, 8'h00, -1, -1);
      chk("byp_addr", r_maddr, 16'h6007);
      chk("byp_beats", 16'(r_beats), 16'd1);
      chk("byp_burst", {15'd0, r_burst}, 16'd0);
      chk("byp_rdata", {8'd0, bus.cpu_rdata}, 16'h00F7);
      access(16'h6007, 1'b0, 1'b1, 8'h00, -1, -1);
      chk("noalloc_beats", 16'(r_beats), 16'd8);
      chk("noalloc_count", hit_count, 16'd3);

      // Disable during a fill: byte still delivered, line left invalid.
      access(16'h8006, 1'b0, 1'b1, 8'h00, -1, 2);
      chk("drop_beats", 16'(r_beats), 16'd8);
      chk("drop_rdata", {8'd0, bus.cpu_rdata}, 16'h0016);
      access(16'h8006, 1'b0, 1'b1, 8'h00, -1, -1);
      chk("drop_remiss", 16'(r_beats), 16'd8);
      access(16'h8006, 1'b0, 1'b1, 8'h00, -1, -1);
      chk("drop_nowhit", 16'(r_beats), 16'd0);

      // Cache disabled: cached line is bypassed, then invalid after re-enable.
      icache_en = 1'b0;
      access(16'h8006, 1'b0, 1'b1, 8'h00, -1, -1);
      chk("dis_beats", 16'(r_beats), 16'd1);
      chk("dis_burst", {15'd0, r_burst}, 16'd0);
      icache_en = 1'b1;
      access(16'h8006, 1'b0, 1'b1, 8'h00, -1, -1);
      chk("dis_remiss", 16'(r_beats), 16'd8);

      // Reset during beat 4 of a fill.
      access(16'h9001, 1'b0, 1'b1, 8'h00, 4, -1);
      chk("rstf_rdy", {15'd0, bus.cpu_rdy}, 16'd1);
      chk("rstf_mem_en", {15'd0, bus.mem_en}, 16'd0);
      chk("rstf_rburst", {15'd0, bus.mem_rburst}, 16'd0);
      chk("rstf_rdata", {8'd0, bus.cpu_rdata}, 16'h0000);
      chk("rstf_hits", hit_count, 16'd0);
      rst = 1'b0;
      bus.mem_rdata0     = 8'h77;
      bus.mem_rdata_load = 1'b1;
      @(negedge clk);
      bus.mem_rdata_load = 1'b0;
      chk("stray_rdata", {8'd0, bus.cpu_rdata}, 16'h0000);
      chk("stray_mem_en", {15'd0, bus.mem_en}, 16'd0);
      access(16'h8006, 1'b0, 1'b1, 8'h00, -1, -1);
      chk("rstf_inval", 16'(r_beats), 16'd8);
      access(16'h9001, 1'b0, 1'b1, 8'h00, -1, -1);
      chk("rstf_refill", 16'(r_beats), 16'd8);
      chk("rstf_refill_rd", {8'd0, bus.cpu_rdata}, 16'h0021);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/cache_6502_assoc.md
CACHE_6502_ASSOC -- requirements
Module: cache_6502_assoc

Interface
REQ-001 SHALL have parameter NUM_LINES, default 4, number of fully-associative lines (power of two, 2..16).
REQ-002 SHALL have parameter LINE_BYTES, default 8, bytes per line (power of two, 4..32); OFF_W = log2(LINE_BYTES), TAG_W = 16-OFF_W.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port icache_en  input  1  cache enable; low = bypass and invalidate.
REQ-006 SHALL have ports cpu_addr input 16, cpu_en input 1, cpu_wr input 1, cpu_iread input 1 (opcode/operand fetch), cpu_wdata input 8.
REQ-007 SHALL have ports cpu_rdy output 1 (request accepted this cycle), cpu_rdata output 8 (registered read data).
REQ-008 SHALL have ports mem_addr output 16, mem_en output 1, mem_wr output 1, mem_rburst output 1, mem_wdata output 8.
REQ-009 SHALL have ports mem_rdata0 input 8 (returned byte), mem_rdata_load input 1 (mem_rdata0 valid this cycle).
REQ-010 SHALL have port hit_count output 16, saturating count of cache-hit reads.

Function
REQ-011 SHALL implement states READY, MEM_WAIT, IFILL; cpu_rdy = 1 only in READY.
REQ-012 In READY with cpu_en=0, SHALL hold mem_en=0 and stay in READY.
REQ-013 In READY, read (cpu_en=1, cpu_wr=0) with icache_en=1 and tag match on a valid line SHALL load cpu_rdata from that line next edge, mem_en=0, stay READY (hit latency 1 cycle, zero stall).
REQ-014 If several lines match (error), the lowest index SHALL win.
REQ-015 In READY, read miss with icache_en=1 and cpu_iread=1 SHALL drive mem_addr={cpu_addr[15:OFF_W],0}, mem_en=1, save cpu_addr, write tag into victim line marked invalid, enter IFILL.
REQ-016 In IFILL, mem_en=mem_rburst=1 until the LINE_BYTES-th mem_rdata_load; each mem_rdata_load SHALL write mem_rdata0 at fill offset (0..LINE_BYTES-1, incrementing).
REQ-017 In IFILL, cpu_rdata SHALL load mem_rdata0 when fill offset equals saved cpu_addr[OFF_W-1:0].
REQ-018 On last fill byte SHALL set victim valid, advance victim pointer by 1 (mod NUM_LINES), return to READY next cycle, mem_en=0.
REQ-019 All other accesses (write, non-iread miss, any access with icache_en=0) SHALL drive mem_en=1, mem_addr=cpu_addr, mem_rburst=0, enter MEM_WAIT.
REQ-020 mem_wr SHALL equal cpu_wr and mem_wdata cpu_wdata in READY; mem_wr=0 in IFILL.
REQ-021 In MEM_WAIT, mem_en=1; on mem_rdata_load, reads SHALL load cpu_rdata from mem_rdata0; return to READY next cycle.
REQ-022 Write accepted in READY hitting a valid line SHALL update that byte in the same edge (write-through); write miss SHALL not allocate.
REQ-023 Victim pointer SHALL be round-robin, unaffected by hits.
REQ-024 hit_count SHALL increment on each REQ-013 hit, saturating at 16'hFFFF.
REQ-025 icache_en=0 SHALL clear all valid bits and victim pointer every cycle it is low.
REQ-026 icache_en falling during IFILL SHALL complete the burst and deliver the requested byte, but line SHALL remain invalid.
REQ-027 Fill tag invalidated at IFILL entry SHALL not hit until fill completes.

Reset
REQ-028 rst SHALL force state READY, all valid bits 0, victim pointer 0, fill offset 0, cpu_rdata 8'h00, hit_count 0, mem_en 0, mem_rburst 0 at the next edge.
REQ-029 rst asserted mid-IFILL or mid-MEM_WAIT SHALL abandon the transaction; line being filled SHALL stay invalid; subsequent mem_rdata_load ignored until a new request.

Verification
REQ-030 Reset, icache_en=1, iread 16'h1003 miss, memory returns A0..A7 -> mem_addr 16'h1000, mem_rburst 8 beats, cpu_rdata=A3, cpu_rdy low until READY, line 0 valid.
REQ-031 Then iread 16'h1005 -> no mem_en, cpu_rdata=A5 next cycle, hit_count=1.
REQ-032 Fill 5 distinct lines (NUM_LINES=4) -> fifth fill replaces line 0; re-read of first line address misses.
REQ-033 Write 8'h5C to 16'h1002 while cached -> mem_wr=1 write-through; later iread 16'h1002 hits returning 8'h5C.
REQ-034 Drop icache_en mid-fill, then reassert -> burst completes, requested byte returned, next read of that line misses.
REQ-035 Assert rst during IFILL beat 4 -> READY next cycle, all outputs at reset values, no line valid.
